// File: rtl/rbm_batch_controller_pkg.sv
// Shared definitions for the RBM batch controller: FSM encoding and result-word layout.
// The optional argmax field is enabled by defining RBM_BATCH_ARGMAX_EN (undefined by default).
package rbm_batch_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERST = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Result word, LSB first: data | tag | timeout | class (class only with argmax).
    function automatic int tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int timeout_bit(input int data_w, input int tag_w);
        return data_w + tag_w;
    endfunction

    function automatic int class_lsb(input int data_w, input int tag_w);
        return data_w + tag_w + 1;
    endfunction

    function automatic int class_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/rbm_batch_controller_if.sv
// Host-side stream bus of the batch controller: input vectors in, tagged results out.
interface rbm_batch_controller_if
    import rbm_batch_controller_pkg::*;
#(
    parameter int bitlength  = 12,
    parameter int input_dim  = 4,
    parameter int output_dim = 2,
    parameter int tag_width  = 8
);
    localparam int class_w = class_width(output_dim);

    logic                            in_valid;
    logic                            in_ready;
    logic [input_dim*bitlength-1:0]  in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [output_dim*bitlength-1:0] out_data;
    logic [tag_width-1:0]            out_tag;
    logic                            out_timeout;
    logic [class_w-1:0]              out_class;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_timeout, out_class
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_timeout, out_class
    );

endinterface

// File: rtl/rbm_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module rbm_sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[aw-1:0]] <= push_data;
    end

endmodule

// File: rtl/rbm_batch_controller.sv
// Batch sequencer around the RBM engine: buffers vectors, runs each through the engine with a watchdog, queues tagged results.
// Define RBM_BATCH_ARGMAX_EN to add a registered signed argmax class to every result.
module rbm_batch_controller
    import rbm_batch_controller_pkg::*;
#(
    parameter int bitlength      = 12,
    parameter int input_dim      = 4,
    parameter int output_dim     = 2,
    parameter int in_depth       = 8,
    parameter int out_depth      = 4,
    parameter int tag_width      = 8,
    parameter int timeout_cycles = 4096
) (
    input  logic                             clock,
    input  logic                             reset,
    rbm_batch_controller_if.slave            bus,
    output logic                             eng_reset,
    output logic                             eng_data_valid,
    output logic [input_dim*bitlength-1:0]   eng_input,
    input  logic [output_dim*bitlength-1:0]  eng_output,
    input  logic                             eng_finish,
    output logic                             busy
);
    localparam int in_w    = input_dim * bitlength;
    localparam int data_w  = output_dim * bitlength;
    localparam int class_w = class_width(output_dim);
    localparam int tag_lo  = tag_lsb(data_w);
    localparam int to_bit  = timeout_bit(data_w, tag_width);
    localparam int wd_w    = $clog2(timeout_cycles + 1);
`ifdef RBM_BATCH_ARGMAX_EN
    localparam int cls_lo  = class_lsb(data_w, tag_width);
    localparam int res_w   = cls_lo + class_w;
`else
    localparam int res_w   = to_bit + 1;
`endif

    state_t              state_q, state_d;
    logic [in_w-1:0]     eng_input_q;
    logic [in_w-1:0]     in_head;
    logic                in_full, in_empty, in_pop;
    logic [res_w-1:0]    res_word, out_head, out_word;
    logic                out_full, out_empty, out_pop, out_push;
    logic [data_w-1:0]   res_data_q;
    logic                res_timeout_q;
    logic [tag_width-1:0] tag_q;
    logic [wd_w-1:0]     wd_q;
    logic                fin_q, fin_edge, wd_limit, capture;

    rbm_sync_fifo #(.width(in_w), .depth(in_depth)) u_in_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.in_valid && !in_full),
        .push_data (bus.in_data),
        .pop       (in_pop),
        .pop_data  (in_head),
        .full      (in_full),
        .empty     (in_empty)
    );

    rbm_sync_fifo #(.width(res_w), .depth(out_depth)) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (out_push),
        .push_data (res_word),
        .pop       (out_pop),
        .pop_data  (out_head),
        .full      (out_full),
        .empty     (out_empty)
    );

    // The first RUN cycle only samples the finish level, so a level left high is never taken as an edge.
    assign fin_edge = eng_finish && !fin_q && (wd_q != '0);
    assign wd_limit = (wd_q == wd_w'(timeout_cycles - 1));
    assign out_pop  = !out_empty && bus.out_ready;

    always_comb begin
        state_d  = state_q;
        in_pop   = 1'b0;
        capture  = 1'b0;
        out_push = 1'b0;
        case (state_q)
            IDLE: if (!in_empty) begin
                in_pop  = 1'b1;
                state_d = ERST;
            end
            ERST: state_d = RUN;
            RUN: if (fin_edge || wd_limit) begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: if (!out_full || out_pop) begin
                out_push = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RBM_BATCH_ARGMAX_EN
    logic [class_w-1:0]          argmax, class_q;
    logic signed [bitlength-1:0] best;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        argmax = '0;
        best   = $signed(eng_output[bitlength-1:0]);
        for (int i = 1; i < output_dim; i++) begin
            if ($signed(eng_output[i*bitlength +: bitlength]) > best) begin
                best   = $signed(eng_output[i*bitlength +: bitlength]);
                argmax = class_w'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)        class_q <= '0;
        else if (capture) class_q <= fin_edge ? argmax : '0;
    end

    assign res_word      = {class_q, res_timeout_q, tag_q, res_data_q};
`else
    assign res_word      = {res_timeout_q, tag_q, res_data_q};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            eng_input_q   <= '0;
            fin_q         <= 1'b0;
            wd_q          <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            tag_q         <= '0;
        end else begin
            state_q <= state_d;
            if (in_pop) eng_input_q <= in_head;
            if (state_q == ERST) begin
                fin_q <= 1'b0;
                wd_q  <= '0;
            end
            if (state_q == RUN) begin
                fin_q <= eng_finish;
                wd_q  <= wd_q + 1'b1;
            end
            if (capture) begin
                res_data_q    <= fin_edge ? eng_output : '0;
                res_timeout_q <= !fin_edge;
            end
            if (out_push) tag_q <= tag_q + 1'b1;
        end
    end

    // FIFO storage is not reset, so the head is masked to zero while nothing is queued.
    assign out_word        = out_empty ? '0 : out_head;
    assign bus.in_ready    = !in_full;
    assign bus.out_valid   = !out_empty;
    assign bus.out_data    = out_word[data_w-1:0];
    assign bus.out_tag     = out_word[tag_lo +: tag_width];
    assign bus.out_timeout = out_word[to_bit];
`ifdef RBM_BATCH_ARGMAX_EN
    assign bus.out_class   = out_word[cls_lo +: class_w];
`else
    assign bus.out_class   = '0;
`endif

    assign eng_reset      = reset | (state_q == ERST);
    assign eng_data_valid = (state_q == RUN);
    assign eng_input      = eng_input_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_rbm_batch_controller.sv
// Self-checking bench for rbm_batch_controller: engine responder, result scoreboard and directed scenarios.
module tb_rbm_batch_controller;
    localparam int TO = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        eng_reset, eng_data_valid, eng_finish, busy;
    logic [47:0] eng_input;
    logic [23:0] eng_output;

    rbm_batch_controller_if #(.bitlength(12), .input_dim(4), .output_dim(2), .tag_width(8)) bus ();

    rbm_batch_controller #(
        .bitlength(12), .input_dim(4), .output_dim(2), .in_depth(8),
        .out_depth(4), .tag_width(8), .timeout_cycles(TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .eng_reset      (eng_reset),
        .eng_data_valid (eng_data_valid),
        .eng_input      (eng_input),
        .eng_output     (eng_output),
        .eng_finish     (eng_finish),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] data;
        logic [7:0]  tag;
        logic        timeout;
        logic [0:0]  cls;
    } exp_t;

`ifdef RBM_BATCH_ARGMAX_EN
    localparam bit argmax_en = 1'b1;
`else
    localparam bit argmax_en = 1'b0;
`endif

    int          n_pass = 0;
    int          n_checks = 0;
    int          cyc = 0;
    int          eng_delay = 20;
    bit          eng_stuck = 1'b0;
    int          eng_cnt = 0, cnt_next = 0;
    logic        fin_next = 1'b0;
    exp_t        exp_q[$];
    logic [47:0] vec_q[$];
    logic [47:0] cur_vec = '0;
    logic [7:0]  tag_model = '0;
    bit          prev_dv = 1'b0;

    always @(posedge clock) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [0:0] model_class(input logic [23:0] d, input bit timed);
        int best_i, best_v, v;
        best_i = 0;
        best_v = $signed(d[11:0]);
        for (int i = 1; i < 2; i++) begin
            v = $signed(d[i*12 +: 12]);
            if (v > best_v) begin
                best_v = v;
                best_i = i;
            end
        end
        return (argmax_en && !timed) ? 1'(best_i) : 1'b0;
    endfunction

    // Engine responder: raises finish eng_delay cycles after data_valid starts; reset clears it unless stuck.
    assign eng_output = eng_input[23:0];
    initial eng_finish = 1'b0;

    always @(negedge clock) begin
        if (eng_reset) begin
            cnt_next = 0;
            fin_next = eng_stuck;
        end else if (eng_data_valid) begin
            cnt_next = eng_cnt + 1;
            fin_next = eng_finish | (eng_cnt + 1 == eng_delay) | eng_stuck;
        end else begin
            cnt_next = eng_cnt;
            fin_next = eng_finish | eng_stuck;
        end
    end

    always @(posedge clock) begin
        #1;
        eng_cnt    = cnt_next;
        eng_finish = fin_next;
    end

    // Scoreboard: every accepted vector becomes one expected result when its run starts.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            vec_q.delete();
            tag_model = '0;
            prev_dv   = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check_output("result_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check_output("out_data",    64'(bus.out_data),    64'(exp_q[0].data));
                    check_output("out_tag",     64'(bus.out_tag),     64'(exp_q[0].tag));
                    check_output("out_timeout", 64'(bus.out_timeout), 64'(exp_q[0].timeout));
                    check_output("out_class",   64'(bus.out_class),   64'(exp_q[0].cls));
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) vec_q.push_back(bus.in_data);
            if (eng_data_valid && !prev_dv) begin
                exp_t e;
                bit   timed;
                check_output("vector_pending", 64'(vec_q.size() != 0), 64'd1);
                if (vec_q.size() != 0) cur_vec = vec_q.pop_front();
                timed     = eng_stuck || (eng_delay >= TO);
                e.data    = timed ? 24'h0 : cur_vec[23:0];
                e.tag     = tag_model;
                e.timeout = timed;
                e.cls     = model_class(e.data, timed);
                exp_q.push_back(e);
                tag_model = tag_model + 8'd1;
            end
            if (eng_data_valid) check_output("eng_input", 64'(eng_input), 64'(cur_vec));
            prev_dv = eng_data_valid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [47:0] vec, output int push_cyc);
        bit ok = 1'b0;
        push_cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = vec;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            ok = bus.in_ready;
            push_cyc = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) check_output("push_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_out_valid(input int max, input string name, output int at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        check_output({name, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic drain(input int max);
        bit done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge clock);
            done = !busy && !bus.out_valid && exp_q.size() == 0 && vec_q.size() == 0;
        end
        check_output("drain", 64'(done), 64'd1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int t, c;
        bit seen;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clock);
        check_output("eng_reset_during_reset", 64'(eng_reset), 64'd1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_output("rst_in_ready",    64'(bus.in_ready),    64'd1);
        check_output("rst_out_valid",   64'(bus.out_valid),   64'd0);
        check_output("rst_out_data",    64'(bus.out_data),    64'd0);
        check_output("rst_out_tag",     64'(bus.out_tag),     64'd0);
        check_output("rst_out_timeout", 64'(bus.out_timeout), 64'd0);
        check_output("rst_out_class",   64'(bus.out_class),   64'd0);
        check_output("rst_data_valid",  64'(eng_data_valid),  64'd0);
        check_output("rst_eng_input",   64'(eng_input),       64'd0);
        check_output("rst_busy",        64'(busy),            64'd0);
        check_output("rst_eng_reset",   64'(eng_reset),       64'd0);
        tick();

        $display("[TB] single sample, finish 20 cycles after data_valid");
        eng_delay = 20;
        apply_stimulus({12'h0AA, 12'h0BB, 12'h7FF, 12'h123}, t);
        wait_out_valid(100, "single", c);
        check_output("single_latency", 64'(c - t), 64'd25);
        check_output("single_data",    64'(bus.out_data),    64'h7FF123);
        check_output("single_tag",     64'(bus.out_tag),     64'd0);
        check_output("single_timeout", 64'(bus.out_timeout), 64'd0);
        check_output("single_class",   64'(bus.out_class),   64'(argmax_en ? 1 : 0));
        drain(100);

        $display("[TB] engine never finishes");
        eng_delay = 1000;
        tick();
        apply_stimulus({12'h001, 12'h002, 12'h345, 12'h678}, t);
        wait_out_valid(100, "timeout", c);
        check_output("timeout_latency", 64'(c - t), 64'd36);
        check_output("timeout_flag",    64'(bus.out_timeout), 64'd1);
        check_output("timeout_data",    64'(bus.out_data),    64'd0);
        check_output("timeout_tag",     64'(bus.out_tag),     64'd1);
        drain(100);

        $display("[TB] finish edge on the watchdog limit cycle");
        eng_delay = TO - 1;
        tick();
        apply_stimulus({12'h003, 12'h004, 12'h9AB, 12'h0CD}, t);
        wait_out_valid(100, "limit_tie", c);
        check_output("limit_tie_latency", 64'(c - t), 64'd36);
        check_output("limit_tie_timeout", 64'(bus.out_timeout), 64'd0);
        check_output("limit_tie_data",    64'(bus.out_data),    64'h9AB0CD);
        check_output("limit_tie_tag",     64'(bus.out_tag),     64'd2);
        drain(100);

        $display("[TB] finish stuck high from previous sample");
        eng_stuck = 1'b1;
        tick();
        apply_stimulus({12'h005, 12'h006, 12'h111, 12'h222}, t);
        wait_out_valid(100, "stuck", c);
        check_output("stuck_timeout", 64'(bus.out_timeout), 64'd1);
        check_output("stuck_data",    64'(bus.out_data),    64'd0);
        drain(100);
        eng_stuck = 1'b0;

        $display("[TB] nine vectors back-to-back with a slow engine");
        eng_delay = 30;
        tick();
        for (int i = 0; i < 9; i++) begin
            apply_stimulus({12'(i), 12'(i * 3),
                            (i % 2 == 1) ? 12'h800 + 12'(i) : 12'h200 + 12'(i),
                            12'h100 + 12'(i * 7)}, t);
        end
        @(negedge clock);
        check_output("in_full_ready", 64'(bus.in_ready), 64'd0);
        drain(1000);

        $display("[TB] output backpressure over six samples");
        eng_delay = 5;
        bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus({12'h0, 12'h0, 12'(16 * i), 12'hFF0 - 12'(i)}, t);
        end
        repeat (100) @(negedge clock);
        check_output("bp_out_valid", 64'(bus.out_valid),    64'd1);
        check_output("bp_busy",      64'(busy),             64'd1);
        check_output("bp_no_run",    64'(eng_data_valid),   64'd0);
        check_output("bp_head_tag",  64'(bus.out_tag),      64'd13);
        check_output("bp_in_ready",  64'(bus.in_ready),     64'd1);
        tick();
        drain(300);

        $display("[TB] reset during RUN");
        eng_delay = 20;
        tick();
        apply_stimulus({12'h00F, 12'h00E, 12'h300, 12'h400}, t);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = eng_data_valid;
        end
        check_output("midrun_reached_run", 64'(seen), 64'd1);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clock);
        check_output("midrun_eng_reset", 64'(eng_reset), 64'd1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_output("midrun_out_valid",  64'(bus.out_valid),  64'd0);
        check_output("midrun_busy",       64'(busy),           64'd0);
        check_output("midrun_data_valid", 64'(eng_data_valid), 64'd0);
        check_output("midrun_eng_input",  64'(eng_input),      64'd0);
        check_output("midrun_in_ready",   64'(bus.in_ready),   64'd1);
        check_output("midrun_out_tag",    64'(bus.out_tag),    64'd0);
        repeat (40) @(negedge clock);
        check_output("midrun_no_partial", 64'(bus.out_valid),  64'd0);
        eng_delay = 10;
        tick();
        apply_stimulus({12'h0, 12'h0, 12'h005, 12'h005}, t);
        wait_out_valid(100, "tie", c);
        check_output("tie_tag",   64'(bus.out_tag),   64'd0);
        check_output("tie_class", 64'(bus.out_class), 64'd0);
        check_output("tie_data",  64'(bus.out_data),  64'h005005);
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
